// File: rtl/icsp_loader_pkg.sv
// Shared definitions for the serial in-circuit programming front-end:
// command codes, frame lengths and the loader FSM state encoding.
package icsp_loader_pkg;

  localparam logic [5:0] CMD_LOAD = 6'h02;
  localparam logic [5:0] CMD_READ = 6'h04;
  localparam logic [5:0] CMD_INC  = 6'h06;
  localparam logic [5:0] CMD_PROG = 6'h08;

  localparam int CMD_BITS  = 6;
  localparam int DATA_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DIN,
    DOUT,
    PWAIT
  } state_t;

endpackage

// File: rtl/icsp_sync_edge.sv
// 2-FF synchroniser for an asynchronous pin. With EDGE set, q is a one-cycle
// rising-edge pulse of the synchronised value; otherwise q is the synchronised level.
module icsp_sync_edge #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q
);

  logic s1, s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  if (EDGE) begin : gEdge
    logic s3;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s3 <= 1'b0;
      else        s3 <= s2;
    end
    assign q = s2 & ~s3;
  end else begin : gLevel
    assign q = s2;
  end

endmodule

// File: rtl/icsp_loader.sv
// Serial in-circuit programming loader: decodes host commands on sclk/sdata,
// writes/reads program memory and holds the core in reset while programming.
module icsp_loader
  import icsp_loader_pkg::*;
#(
  parameter int INST_W      = 12,
  parameter int ADDR_W      = 9,
  parameter int PROG_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_en,
  input  logic              sclk,
  input  logic              sdata,
  output logic              sdo,
  output logic              sdo_oe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [INST_W-1:0] memWrData,
  output logic              memWrEn,
  input  logic [INST_W-1:0] memRdData,
  output logic              busy,
  output logic              core_rst_n
);

  localparam int CNT_W = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;

  logic progSync, progPrev, progRise, progFall;
  logic sclkRise, sdataSync;

  state_t              state;
  logic [4:0]          bitCnt;
  logic                cmdPend;
  logic [CMD_BITS-1:0] cmdShift;
  logic [INST_W-1:0]   dataShift, dataNext, outShift;
  logic                dataInRange;
  logic [CNT_W-1:0]    progCnt;

  icsp_sync_edge #(.EDGE(1'b0)) uProgSync (
    .clk(clk), .rst_n(rst_n), .din(prog_en), .q(progSync)
  );
  icsp_sync_edge #(.EDGE(1'b1)) uSclkEdge (
    .clk(clk), .rst_n(rst_n), .din(sclk), .q(sclkRise)
  );
  icsp_sync_edge #(.EDGE(1'b0)) uSdataSync (
    .clk(clk), .rst_n(rst_n), .din(sdata), .q(sdataSync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) progPrev <= 1'b0;
    else        progPrev <= progSync;
  end

  assign progRise = progSync & ~progPrev;
  assign progFall = ~progSync & progPrev;

  // Data frame bit 0 is the start bit; bits 1..INST_W carry the word LSB first.
  assign dataInRange = (bitCnt != '0) && (bitCnt <= 5'(INST_W));
  assign dataNext    = dataInRange ? {sdataSync, dataShift[INST_W-1:1]} : dataShift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bitCnt     <= '0;
      cmdPend    <= 1'b0;
      cmdShift   <= '0;
      dataShift  <= '0;
      outShift   <= '0;
      progCnt    <= '0;
      sdo        <= 1'b0;
      sdo_oe     <= 1'b0;
      memAddr    <= '0;
      memWrData  <= '0;
      memWrEn    <= 1'b0;
      busy       <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      memWrEn <= 1'b0;
      if (progFall && state != IDLE) begin
        state   <= IDLE;
        bitCnt  <= '0;
        cmdPend <= 1'b0;
        progCnt <= '0;
        sdo     <= 1'b0;
        sdo_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (progRise) begin
              state      <= CMD;
              memAddr    <= '0;
              bitCnt     <= '0;
              cmdPend    <= 1'b0;
              core_rst_n <= 1'b0;
            end else begin
              core_rst_n <= 1'b1;
            end
          end
          CMD: begin
            // Dispatch is one cycle after the last command bit so the write
            // strobe never lands on a sampling edge.
            if (cmdPend) begin
              cmdPend <= 1'b0;
              case (cmdShift)
                CMD_LOAD: state <= DIN;
                CMD_READ: begin
                  outShift <= memRdData;
                  sdo      <= 1'b0;
                  sdo_oe   <= 1'b1;
                  state    <= DOUT;
                end
                CMD_INC:  memAddr <= memAddr + ADDR_W'(1);
                CMD_PROG: begin
                  memWrEn <= 1'b1;
                  busy    <= 1'b1;
                  progCnt <= '0;
                  state   <= PWAIT;
                end
                default: ;
              endcase
            end else if (sclkRise) begin
              cmdShift <= {sdataSync, cmdShift[CMD_BITS-1:1]};
              if (bitCnt == 5'(CMD_BITS - 1)) begin
                bitCnt  <= '0;
                cmdPend <= 1'b1;
              end else begin
                bitCnt <= bitCnt + 5'd1;
              end
            end
          end
          DIN: begin
            if (sclkRise) begin
              dataShift <= dataNext;
              if (bitCnt == 5'(DATA_BITS - 1)) begin
                memWrData <= dataNext;
                bitCnt    <= '0;
                state     <= CMD;
              end else begin
                bitCnt <= bitCnt + 5'd1;
              end
            end
          end
          DOUT: begin
            if (sclkRise) begin
              if (bitCnt == 5'(DATA_BITS - 1)) begin
                sdo    <= 1'b0;
                sdo_oe <= 1'b0;
                bitCnt <= '0;
                state  <= CMD;
              end else begin
                sdo      <= outShift[0];
                outShift <= outShift >> 1;
                bitCnt   <= bitCnt + 5'd1;
              end
            end
          end
          PWAIT: begin
            if (progCnt == CNT_W'(PROG_CYCLES - 1)) begin
              busy    <= 1'b0;
              progCnt <= '0;
              state   <= CMD;
            end else begin
              progCnt <= progCnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icsp_loader.sv
// Directed bench for icsp_loader: a host-level model of address, write latch,
// write log and read frames is checked against the DUT on every quiet cycle.
module tb_icsp_loader;
  import icsp_loader_pkg::*;

  localparam int INST_W      = 12;
  localparam int ADDR_W      = 9;
  localparam int PROG_CYCLES = 64;
  localparam int HALF        = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              prog_en = 1'b0;
  logic              sclk = 1'b0;
  logic              sdata = 1'b0;
  logic              sdo, sdo_oe, memWrEn, busy, core_rst_n;
  logic [ADDR_W-1:0] memAddr;
  logic [INST_W-1:0] memWrData, memRdData;

  logic [INST_W-1:0] memArr [512];
  logic [INST_W-1:0] mMem   [512];

  int tests = 0;
  int fails = 0;
  int busyRun = 0;

  logic              chkEn = 1'b0;
  logic              mProg = 1'b0;
  logic              mReading = 1'b0;
  logic [ADDR_W-1:0] mAddr = '0;
  logic [INST_W-1:0] mData = '0;
  logic [20:0]       expWr [$];
  logic [15:0]       rx;

  icsp_loader #(.INST_W(INST_W), .ADDR_W(ADDR_W), .PROG_CYCLES(PROG_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .prog_en(prog_en), .sclk(sclk), .sdata(sdata),
    .sdo(sdo), .sdo_oe(sdo_oe), .memAddr(memAddr), .memWrData(memWrData),
    .memWrEn(memWrEn), .memRdData(memRdData), .busy(busy), .core_rst_n(core_rst_n)
  );

  always #5 clk = ~clk;

  // Program memory environment
  assign memRdData = memArr[memAddr];
  always @(posedge clk) if (memWrEn) memArr[memAddr] <= memWrData;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendBits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      sdata = v[i];
      waitClk(HALF);
      sclk = 1'b1;
      waitClk(HALF);
    end
  endtask

  task automatic doCmd(input logic [5:0] c);
    chkEn = 1'b0;
    if (c == CMD_PROG) begin
      expWr.push_back({mAddr, mData});
      mMem[mAddr] = mData;
    end
    sendBits({10'b0, c}, CMD_BITS);
    if (c == CMD_INC) mAddr = mAddr + 9'd1;
    if (c == CMD_READ) mReading = 1'b1;
    if (c != CMD_LOAD) chkEn = 1'b1;
  endtask

  task automatic loadWord(input logic [INST_W-1:0] w);
    doCmd(CMD_LOAD);
    sendBits({3'b101, w, 1'b1}, DATA_BITS);
    mData = w;
    chkEn = 1'b1;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      if (memWrEn) begin
        if (expWr.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL write_unexpected: got addr %0h data %0h expected no write", memAddr, memWrData);
        end else begin
          check("write", 32'({memAddr, memWrData}), 32'(expWr.pop_front()));
        end
      end
      if (busy) busyRun++;
      else if (busyRun != 0) begin
        check("busy_len", 32'(busyRun), 32'(PROG_CYCLES));
        busyRun = 0;
      end
      if (chkEn)
        check("outputs", 32'({memAddr, memWrData, core_rst_n, sdo_oe, sdo & ~mReading}),
              32'({mAddr, mData, ~mProg, mReading, 1'b0}));
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      memArr[i] = 12'(i * 7 + 3);
      mMem[i]   = 12'(i * 7 + 3);
    end
    memArr[5] = 12'h3C7;
    mMem[5]   = 12'h3C7;

    // Reset with programming requested
    prog_en = 1'b1;
    waitClk(4);
    check("rst_sdo", 32'(sdo), 32'(0));
    check("rst_sdo_oe", 32'(sdo_oe), 32'(0));
    check("rst_memAddr", 32'(memAddr), 32'(0));
    check("rst_memWrData", 32'(memWrData), 32'(0));
    check("rst_memWrEn", 32'(memWrEn), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_core_rst_n", 32'(core_rst_n), 32'(0));
    rst_n = 1'b1;
    waitClk(8);
    check("entry_core_rst_n", 32'(core_rst_n), 32'(0));
    check("entry_memAddr", 32'(memAddr), 32'(0));
    mProg = 1'b1;
    chkEn = 1'b1;

    // Load then program; sclk edges during busy must be ignored
    loadWord(12'hA5C);
    check("load_word", 32'(memWrData), 32'(12'hA5C));
    doCmd(CMD_PROG);
    check("busy_set", 32'(busy), 32'(1));
    sendBits(16'h0007, 3);
    check("busy_still", 32'(busy), 32'(1));
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check("busy_release", 32'(busy), 32'(0));
    check("mem0_written", 32'(memArr[0]), 32'(12'hA5C));
    doCmd(CMD_INC);
    check("inc_after_busy", 32'(memAddr), 32'(1));

    // Unknown command, then a normal load
    doCmd(6'h3F);
    check("unknown_addr", 32'(memAddr), 32'(1));
    check("unknown_data", 32'(memWrData), 32'(12'hA5C));
    loadWord(12'h5A3);
    check("load_after_unknown", 32'(memWrData), 32'(12'h5A3));

    // Abort mid data frame
    doCmd(CMD_LOAD);
    sendBits(16'hFFFF, 8);
    prog_en = 1'b0;
    waitClk(3);
    check("abort_hold", 32'(core_rst_n), 32'(0));
    waitClk(1);
    check("abort_release", 32'(core_rst_n), 32'(1));
    check("abort_data", 32'(memWrData), 32'(12'h5A3));
    mProg = 1'b0;
    chkEn = 1'b1;
    waitClk(6);
    chkEn = 1'b0;
    prog_en = 1'b1;
    waitClk(8);
    mAddr = '0;
    mProg = 1'b1;
    chkEn = 1'b1;

    // Address increment wrap
    for (int i = 0; i < 511; i++) doCmd(CMD_INC);
    check("wrap_1ff", 32'(memAddr), 32'(9'h1FF));
    doCmd(CMD_INC);
    check("wrap_zero", 32'(memAddr), 32'(0));
    for (int i = 0; i < 5; i++) doCmd(CMD_INC);
    check("addr5", 32'(memAddr), 32'(5));

    // Read frame: start bit, word LSB first, trailing zeros
    doCmd(CMD_READ);
    chkEn = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      sclk = 1'b0;
      sdata = 1'b0;
      waitClk(HALF);
      check("read_oe", 32'(sdo_oe), 32'(1));
      rx[i] = sdo;
      sclk = 1'b1;
      waitClk(HALF);
    end
    mReading = 1'b0;
    chkEn = 1'b1;
    check("read_frame", 32'(rx), 32'({3'b000, mMem[mAddr], 1'b0}));
    check("read_literal", 32'(rx), 32'(16'h078E));

    // Asynchronous reset mid data frame
    doCmd(CMD_LOAD);
    sendBits(16'h00FF, 4);
    chkEn = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_addr", 32'(memAddr), 32'(0));
    check("async_rst_data", 32'(memWrData), 32'(0));
    check("async_rst_core", 32'(core_rst_n), 32'(0));
    waitClk(2);

    check("writes_drained", 32'(expWr.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icsp_loader.md
Name: icsp_loader

Overview:
- Serial in-circuit programming front-end that fills the writable program memory upstream of the core's fetch path.
- Receives 6-bit commands and 16-bit data frames on a two-wire serial link (sclk, sdata).
- Writes and reads instruction words through the program-memory port.
- Holds the core in reset while programming mode is active.

Parameters:
- INST_W, 12, instruction word width; must equal the core's instruction width.
- ADDR_W, 9, program-memory address width; must equal the core's PC width.
- PROG_CYCLES, 64, clk cycles busy after each program-memory write.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- prog_en  in  1  async; high = programming mode
- sclk  in  1  async serial clock from host
- sdata  in  1  async serial data from host, LSB first
- sdo  out  1  serial read data
- sdo_oe  out  1  high while sdo is driven
- memAddr  out  ADDR_W  program-memory address
- memWrData  out  INST_W  write data latch
- memWrEn  out  1  one-cycle write strobe
- memRdData  in  INST_W  combinational read of memAddr
- busy  out  1  write cycle in progress
- core_rst_n  out  1  low holds core in reset

Behaviour:
- Reset values: sdo=0, sdo_oe=0, memAddr=0, memWrData=0, memWrEn=0, busy=0, core_rst_n=0. Registered state is IDLE.
- Synchronisation:
  - prog_en, sclk and sdata each pass through a 2-FF synchroniser.
  - An sclk rising edge is detected one cycle after the synchronised value goes 0→1, i.e. 3 clk cycles after the pin edge.
  - sdata is sampled at that detection.
  - The host must hold sclk high/low for at least 4 clk cycles each.
- States: IDLE, CMD, DIN, DOUT, PWAIT.
- IDLE:
  - core_rst_n=1.
  - Synchronised prog_en rising → CMD, memAddr=0, bit count=0, core_rst_n=0 on the same cycle.
- CMD:
  - Shift 6 bits, LSB first.
  - On the 6th edge, decode and dispatch on the next cycle:
    - 0x02 LOAD → DIN.
    - 0x04 READ → capture memRdData into the out-shift register, sdo_oe=1, sdo=0 (start bit), → DOUT.
    - 0x06 INC → memAddr+1, wraps from 2^ADDR_W-1 to 0, → CMD.
    - 0x08 PROG → memWrEn=1 for exactly 1 cycle with current memAddr/memWrData, busy=1, → PWAIT.
    - Any other code → CMD, no effect.
- DIN:
  - 16 edges. Bit 0 is the start bit and is ignored.
  - Bits 1..INST_W form the data word. Remaining bits are ignored.
  - On the 16th edge, memWrData ← shifted word, → CMD.
- DOUT:
  - 16 edges. sdo updates on each detected edge: start bit 0, then word bits LSB first, then zeros.
  - After the 16th edge, sdo_oe=0, sdo=0, → CMD.
- PWAIT:
  - Counter runs PROG_CYCLES cycles, then busy=0 → CMD.
  - sclk edges during PWAIT are ignored; the host must poll busy or wait.
- core_rst_n is 0 in every state except IDLE. It is released on the cycle after returning to IDLE.
- prog_en falling (synchronised) in any state → IDLE on the next cycle:
  - Partial frame discarded, no write.
  - sdo_oe=0, busy=0, counter cleared.
  - A write strobe already issued is not retracted.
- rst_n asserted mid-operation: all outputs go to reset values immediately.
- memWrEn and the 6th CMD edge never coincide, because PROG dispatch is registered.

Decomposition:
- Shared package holds:
  - Command codes CMD_LOAD=6'h02, CMD_READ=6'h04, CMD_INC=6'h06, CMD_PROG=6'h08.
  - Frame lengths CMD_BITS=6, DATA_BITS=16.
  - State encoding.
- One natural sub-module: icsp_sync_edge (2-FF synchroniser plus rising-edge detect), instantiated for sclk. Its sync-only path is reused for prog_en and sdata.

Test Plan:
- Reset: rst_n low with prog_en=1 → all outputs at reset values. After release → CMD, core_rst_n=0, memAddr=0.
- Load then program:
  - Stimulus: LOAD with word 12'hA5C, then PROG.
  - Response: single memWrEn pulse with memAddr=0, memWrData=12'hA5C. busy high for exactly 64 cycles. Edges sent during busy are ignored.
- Increment wrap: 511 INC commands → memAddr=9'h1FF. One more INC → memAddr=0.
- Read:
  - Setup: memRdData model returns 12'h3C7 at address 5 (reached via 5 INC).
  - Stimulus: READ.
  - Response: 16 sdo bits equal 0, then 12'h3C7 LSB first, then three 0s. sdo_oe high only for the frame.
- Abort:
  - Stimulus: drop prog_en after 8 of 16 DIN bits.
  - Response: IDLE, memWrData unchanged, no memWrEn, core_rst_n=1 two cycles later.
- Unknown command 0x3F → no state change apart from returning to CMD. A following LOAD works normally.
